// File: rtl/pe_mac_pool.sv
// Processing element: DEPTH-entry activation/weight scratchpads and a bias register.
// Computes a saturating signed dot-product plus bias, or a running max, and returns it on a valid/ready port.
module pe_mac_pool #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 9,
    parameter  int ACC_WIDTH  = 20,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic [CW-1:0]                len,
    input  logic                         act_wr_en,
    input  logic [DATA_WIDTH-1:0]        act_wr_data,
    input  logic                         wt_wr_en,
    input  logic [DATA_WIDTH-1:0]        wt_wr_data,
    input  logic                         bias_wr_en,
    input  logic [DATA_WIDTH-1:0]        bias_in,
    input  logic                         wr_ptr_clr,
    input  logic                         start,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  pe_out,
    output logic                         sat
);

    localparam int PW     = $clog2(DEPTH);
    localparam int PROD_W = 2 * DATA_WIDTH;

    localparam logic [PW-1:0]                LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0]                DEPTH_C   = CW'(DEPTH);
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0]  POOL_INIT = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic signed [ACC_WIDTH-1:0] sext_data(input logic signed [DATA_WIDTH-1:0] x);
        return {{(ACC_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

    function automatic logic signed [ACC_WIDTH:0] sext_prod(input logic signed [PROD_W-1:0] x);
        return {{(ACC_WIDTH+1-PROD_W){x[PROD_W-1]}}, x};
    endfunction

    // The sum carries one guard bit; a guard/sign disagreement means the true value left the range.
    function automatic logic overflowed(input logic signed [ACC_WIDTH:0] s);
        return s[ACC_WIDTH] != s[ACC_WIDTH-1];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH:0] s);
        if (overflowed(s))
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        return s[ACC_WIDTH-1:0];
    endfunction

    state_t                          r_state;
    state_t                          w_next;

    logic signed [DATA_WIDTH-1:0]    r_act_mem [DEPTH];
    logic signed [DATA_WIDTH-1:0]    r_wt_mem  [DEPTH];
    logic [PW-1:0]                   r_act_ptr;
    logic [PW-1:0]                   r_wt_ptr;
    logic signed [DATA_WIDTH-1:0]    r_bias;

    logic                            r_mode;
    logic [CW-1:0]                   r_len;
    logic [CW-1:0]                   r_idx;

    logic signed [DATA_WIDTH-1:0]    r_act_p1;
    logic signed [PROD_W-1:0]        r_prod_p1;
    logic                            r_vld_p1;

    logic signed [ACC_WIDTH-1:0]     r_acc;
    logic                            r_sat_acc;

    logic                            r_out_valid;
    logic signed [ACC_WIDTH-1:0]     r_pe_out;
    logic                            r_sat_out;

    logic                            w_busy;
    logic                            w_accept;
    logic [CW-1:0]                   w_len_clamped;
    logic [CW-1:0]                   w_idx_next;
    logic [PW-1:0]                   w_rd_idx;
    logic [PW-1:0]                   w_act_wa;
    logic [PW-1:0]                   w_wt_wa;
    logic signed [PROD_W-1:0]        w_act_rd;
    logic signed [PROD_W-1:0]        w_wt_rd;
    logic signed [PROD_W-1:0]        w_prod;
    logic signed [ACC_WIDTH:0]       w_sum;
    logic signed [ACC_WIDTH-1:0]     w_act_ext;

    assign w_busy        = (r_state != S_IDLE);
    assign w_accept      = (r_state == S_IDLE) && start && !r_out_valid;
    assign w_len_clamped = (len > DEPTH_C) ? DEPTH_C : len;
    assign w_idx_next    = r_idx + CW'(1);
    assign w_rd_idx      = r_idx[PW-1:0];
    assign w_act_wa      = wr_ptr_clr ? '0 : r_act_ptr;
    assign w_wt_wa       = wr_ptr_clr ? '0 : r_wt_ptr;

    // Scratchpad and bias writes are only honoured while idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_act_ptr <= '0;
            r_wt_ptr  <= '0;
            r_bias    <= '0;
        end else if (!w_busy) begin
            if (wr_ptr_clr) begin
                r_act_ptr <= act_wr_en ? PW'(1) : '0;
                r_wt_ptr  <= wt_wr_en  ? PW'(1) : '0;
            end else begin
                if (act_wr_en)
                    r_act_ptr <= (r_act_ptr == LAST_PTR) ? '0 : r_act_ptr + PW'(1);
                if (wt_wr_en)
                    r_wt_ptr <= (r_wt_ptr == LAST_PTR) ? '0 : r_wt_ptr + PW'(1);
            end
            if (bias_wr_en)
                r_bias <= bias_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !w_busy && act_wr_en)
            r_act_mem[w_act_wa] <= act_wr_data;
        if (rst && !w_busy && wt_wr_en)
            r_wt_mem[w_wt_wa] <= wt_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (w_len_clamped == '0) ? S_DRAIN : S_RUN;
            S_RUN:   if (w_idx_next == r_len) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  if (r_out_valid && out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode      <= 1'b0;
            r_len       <= '0;
            r_idx       <= '0;
            r_vld_p1    <= 1'b0;
            r_out_valid <= 1'b0;
            r_pe_out    <= '0;
            r_sat_out   <= 1'b0;
        end else begin
            r_vld_p1 <= (r_state == S_RUN);
            if (w_accept) begin
                r_mode <= mode;
                r_len  <= w_len_clamped;
                r_idx  <= '0;
            end else if (r_state == S_RUN) begin
                r_idx <= w_idx_next;
            end
            if (r_state == S_DONE) begin
                if (!r_out_valid) begin
                    r_out_valid <= 1'b1;
                    r_pe_out    <= r_acc;
                    r_sat_out   <= r_sat_acc & ~r_mode;
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    // Stage 1: scratchpad read and full-precision multiply
    assign w_act_rd = PROD_W'(r_act_mem[w_rd_idx]);
    assign w_wt_rd  = PROD_W'(r_wt_mem[w_rd_idx]);
    assign w_prod   = w_act_rd * w_wt_rd;

    always_ff @(posedge clk) begin
        r_act_p1 <= r_act_mem[w_rd_idx];
        if (!r_mode)
            r_prod_p1 <= w_prod;
    end

    // Stage 2: accumulate (saturating MAC) or running max
    assign w_sum     = {r_acc[ACC_WIDTH-1], r_acc} + sext_prod(r_prod_p1);
    assign w_act_ext = sext_data(r_act_p1);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_acc     <= mode ? POOL_INIT : sext_data(r_bias);
            r_sat_acc <= 1'b0;
        end else if (r_vld_p1) begin
            if (!r_mode) begin
                r_acc     <= saturate(w_sum);
                r_sat_acc <= r_sat_acc | overflowed(w_sum);
            end else if (w_act_ext > r_acc) begin
                r_acc <= w_act_ext;
            end
        end
    end

    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign pe_out    = r_pe_out;
    assign sat       = r_sat_out;

endmodule

// File: tb/tb_pe_mac_pool.sv
// Bench for pe_mac_pool: vector table, hand-written corner sequences and random runs
// against a plain-arithmetic reference, on a 20-bit and a 16-bit accumulator instance.
module tb_pe_mac_pool;

    localparam int DW    = 8;
    localparam int DEPTH = 9;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic [CW-1:0] len;
    logic          act_wr_en, wt_wr_en, bias_wr_en, wr_ptr_clr, start, out_ready;
    logic [DW-1:0] act_wr_data, wt_wr_data, bias_in;

    logic               busy20, ov20, sat20;
    logic signed [19:0] pe20;
    logic               busy16, ov16, sat16;
    logic signed [15:0] pe16;

    int total = 0;
    int bad   = 0;

    int     m_act [DEPTH];
    int     m_wt  [DEPTH];
    int     m_bias;
    longint got20, got16;
    longint gsat20, gsat16;

    always #5 clk = ~clk;

    pe_mac_pool #(.DATA_WIDTH(8), .DEPTH(9), .ACC_WIDTH(20)) u_dut20 (
        .clk(clk), .rst(rst), .mode(mode), .len(len),
        .act_wr_en(act_wr_en), .act_wr_data(act_wr_data),
        .wt_wr_en(wt_wr_en), .wt_wr_data(wt_wr_data),
        .bias_wr_en(bias_wr_en), .bias_in(bias_in), .wr_ptr_clr(wr_ptr_clr),
        .start(start), .busy(busy20), .out_valid(ov20), .out_ready(out_ready),
        .pe_out(pe20), .sat(sat20)
    );

    pe_mac_pool #(.DATA_WIDTH(8), .DEPTH(9), .ACC_WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .mode(mode), .len(len),
        .act_wr_en(act_wr_en), .act_wr_data(act_wr_data),
        .wt_wr_en(wt_wr_en), .wt_wr_data(wt_wr_data),
        .bias_wr_en(bias_wr_en), .bias_in(bias_in), .wr_ptr_clr(wr_ptr_clr),
        .start(start), .busy(busy16), .out_valid(ov16), .out_ready(out_ready),
        .pe_out(pe16), .sat(sat16)
    );

    typedef struct {
        int md, ln;
        int a0, a1, a2, a3, af;
        int w0, w1, w2, w3, wf;
        int bias;
        int e20, s20, e16, s16;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp_len(input int ln);
        return (ln > DEPTH) ? DEPTH : ln;
    endfunction

    // Reference: dot product plus bias clipped after every term, or max over the entries.
    task automatic ref_model(input int md, input int ln, input int aw,
                             output longint res, output longint s);
        longint hi, lo, acc;
        hi = (longint'(1) << (aw - 1)) - 1;
        lo = -hi - 1;
        s  = 0;
        if (md != 0) begin
            acc = -128;
            for (int i = 0; i < clamp_len(ln); i++)
                if (m_act[i] > acc) acc = m_act[i];
        end else begin
            acc = m_bias;
            for (int i = 0; i < clamp_len(ln); i++) begin
                acc += longint'(m_act[i]) * longint'(m_wt[i]);
                if (acc > hi) begin acc = hi; s = 1; end
                else if (acc < lo) begin acc = lo; s = 1; end
            end
        end
        res = acc;
    endtask

    task automatic load_pad;
        wr_ptr_clr = 1'b1;
        tick;
        wr_ptr_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            act_wr_en   = 1'b1;
            wt_wr_en    = 1'b1;
            act_wr_data = DW'(m_act[i]);
            wt_wr_data  = DW'(m_wt[i]);
            tick;
        end
        act_wr_en  = 1'b0;
        wt_wr_en   = 1'b0;
        bias_wr_en = 1'b1;
        bias_in    = DW'(m_bias);
        tick;
        bias_wr_en = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!ov20 && cyc < 60) begin
            tick;
            cyc++;
        end
    endtask

    task automatic run_op(input int md, input int ln, input int rdy_delay);
        int     cyc;
        longint e20, s20, e16, s16;
        mode  = md[0];
        len   = CW'(ln);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", busy20, 1);
        wait_valid(cyc);
        chk("latency", cyc, clamp_len(ln) + 2);
        chk("valid16", ov16, 1);
        ref_model(md, ln, 20, e20, s20);
        ref_model(md, ln, 16, e16, s16);
        got20 = pe20; got16 = pe16; gsat20 = sat20; gsat16 = sat16;
        chk("pe_out20", got20, e20);
        chk("sat20", gsat20, s20);
        chk("pe_out16", got16, e16);
        chk("sat16", gsat16, s16);
        for (int k = 0; k < rdy_delay; k++) begin
            tick;
            chk("hold_pe20", pe20, e20);
            chk("hold_valid", ov20, 1);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("valid_after_take", ov20, 0);
        chk("busy_after_take", busy20, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{0, 3, 1, 2, 3, 0, 0, 4, 5, 6, 0, 0, 10, 42, 0, 42, 0};
        vecs[1] = '{1, 4, -3, 7, -128, 5, 0, 0, 0, 0, 0, 0, 0, 7, 0, 7, 0};
        vecs[2] = '{1, 4, -128, -128, -128, -128, -128, 0, 0, 0, 0, 0, 0, -128, 0, -128, 0};
        vecs[3] = '{0, 9, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128, 0, 147456, 0, 32767, 1};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -5, -5, 0, -5, 0};
        vecs[5] = '{1, 0, 5, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0, -128, 0, -128, 0};
        vecs[6] = '{0, 12, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3, 21, 0, 21, 0};
        vecs[7] = '{0, 9, 127, 127, 127, 127, 127, -128, -128, -128, -128, -128, -128, -146432, 0, -32768, 1};

        rst = 1'b0; mode = 1'b0; len = '0; start = 1'b0; out_ready = 1'b0;
        act_wr_en = 1'b0; wt_wr_en = 1'b0; bias_wr_en = 1'b0; wr_ptr_clr = 1'b0;
        act_wr_data = '0; wt_wr_data = '0; bias_in = '0;
        for (int i = 0; i < DEPTH; i++) begin m_act[i] = 0; m_wt[i] = 0; end
        m_bias = 0;
        repeat (2) tick;
        chk("rst_busy20", busy20, 0);
        chk("rst_valid20", ov20, 0);
        chk("rst_pe20", pe20, 0);
        chk("rst_sat20", sat20, 0);
        chk("rst_busy16", busy16, 0);
        chk("rst_valid16", ov16, 0);
        rst = 1'b1;
        tick;
        run_op(0, 0, 0);  // reset bias is zero

        for (int v = 0; v < 8; v++) begin
            m_act[0] = vecs[v].a0; m_act[1] = vecs[v].a1; m_act[2] = vecs[v].a2; m_act[3] = vecs[v].a3;
            m_wt[0]  = vecs[v].w0; m_wt[1]  = vecs[v].w1; m_wt[2]  = vecs[v].w2; m_wt[3]  = vecs[v].w3;
            for (int i = 4; i < DEPTH; i++) begin m_act[i] = vecs[v].af; m_wt[i] = vecs[v].wf; end
            m_bias = vecs[v].bias;
            load_pad;
            run_op(vecs[v].md, vecs[v].ln, 1);
            chk("tbl_pe20", got20, vecs[v].e20);
            chk("tbl_sat20", gsat20, vecs[v].s20);
            chk("tbl_pe16", got16, vecs[v].e16);
            chk("tbl_sat16", gsat16, vecs[v].s16);
        end

        // Stalled output with ignored start pulses
        m_act[0] = 1; m_act[1] = 2; m_act[2] = 3;
        m_wt[0]  = 4; m_wt[1]  = 5; m_wt[2]  = 6;
        m_bias = 10;
        load_pad;
        mode = 1'b0; len = 4'd3; start = 1'b1;
        tick;
        start = 1'b0;
        wait_valid(cyc);
        chk("stall_latency", cyc, 5);
        for (int k = 0; k < 5; k++) begin
            start = (k % 2 == 0);
            tick;
            chk("stall_pe", pe20, 42);
            chk("stall_valid", ov20, 1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("stall_take_valid", ov20, 0);
        chk("stall_take_busy", busy20, 0);
        tick;
        chk("no_queued_start", busy20, 0);

        // Pointer wrap and clear-with-write
        wr_ptr_clr = 1'b1;
        tick;
        wr_ptr_clr = 1'b0;
        wt_wr_en = 1'b1;
        wt_wr_data = 8'd1;   tick;
        wt_wr_data = 8'd100; tick;
        wt_wr_en = 1'b0;
        m_wt[0] = 1; m_wt[1] = 100;
        for (int v = 1; v <= 10; v++) begin
            act_wr_en = 1'b1;
            act_wr_data = DW'(v);
            tick;
            m_act[(v - 1) % DEPTH] = v;
        end
        act_wr_en = 1'b0;
        bias_wr_en = 1'b1; bias_in = '0; tick; bias_wr_en = 1'b0;
        m_bias = 0;
        run_op(0, 1, 0);
        chk("wrap_entry0", got20, 10);
        act_wr_en = 1'b1; wr_ptr_clr = 1'b1; act_wr_data = 8'd50;
        tick;
        wr_ptr_clr = 1'b0; act_wr_data = 8'd7;
        tick;
        act_wr_en = 1'b0;
        m_act[0] = 50; m_act[1] = 7;
        run_op(0, 2, 0);
        chk("clr_with_write", got20, 750);

        // Reset mid-run, then rerun and drop writes while busy
        m_act[0] = 1; m_act[1] = 2; m_act[2] = 3;
        m_wt[0]  = 4; m_wt[1]  = 5; m_wt[2]  = 6;
        m_bias = 10;
        load_pad;
        mode = 1'b0; len = 4'd3; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        m_bias = 0;
        chk("abort_busy20", busy20, 0);
        chk("abort_valid20", ov20, 0);
        chk("abort_busy16", busy16, 0);
        repeat (6) tick;
        chk("abort_no_result", ov20, 0);
        bias_wr_en = 1'b1; bias_in = 8'd10; tick; bias_wr_en = 1'b0;
        m_bias = 10;
        run_op(0, 3, 0);
        chk("rerun_42", got20, 42);
        mode = 1'b0; len = 4'd3; start = 1'b1;
        tick;
        start = 1'b0;
        act_wr_en = 1'b1; act_wr_data = 8'd99; bias_wr_en = 1'b1; bias_in = 8'd77;
        tick;
        act_wr_en = 1'b0; bias_wr_en = 1'b0;
        wait_valid(cyc);
        got20 = pe20;
        chk("busy_write_dropped", got20, 42);
        out_ready = 1'b1; tick; out_ready = 1'b0;
        act_wr_en = 1'b1; act_wr_data = 8'd5; tick; act_wr_en = 1'b0;
        m_act[0] = 5;
        run_op(0, 3, 0);
        chk("ptr_held_while_busy", got20, 58);

        // Random operations against the reference
        for (int it = 0; it < 40; it++) begin
            int md, ln;
            md = int'($urandom_range(0, 1));
            ln = int'($urandom_range(0, 11));
            for (int i = 0; i < DEPTH; i++) begin
                m_act[i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? -128 : 127)
                                                       : int'($urandom_range(0, 255)) - 128;
                m_wt[i]  = ($urandom_range(0, 3) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
            end
            m_bias = int'($urandom_range(0, 255)) - 128;
            load_pad;
            run_op(md, ln, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
